// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file address width, hazard-unit defaults,
// the scoreboard entry layout and the interrupt-entry sequencer states.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned SB_DEPTH    = 2;
  localparam int unsigned FLUSH_DEPTH = 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    INJECT,
    VECTOR
  } int_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Write-back scoreboard: a shift register of in-flight destination registers
// (slot 0 = EX, last slot = WB) with hit detection for both decode sources.
module hazard_scoreboard #(
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] rd_x,
  input  logic [ADDR_W-1:0] rd_y,
  output logic              hit_x,
  output logic              hit_y,
  output logic              busy
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t sb_q [SB_DEPTH];

  // Shifts every clock; the oldest entry simply falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= load_en ? '{valid: 1'b1, addr: load_addr} : '0;
      for (int unsigned i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_comb begin
    hit_x = 1'b0;
    hit_y = 1'b0;
    busy  = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].valid) begin
        busy = 1'b1;
        if (sb_q[i].addr == rd_x) hit_x = 1'b1;
        if (sb_q[i].addr == rd_y) hit_y = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: RAW stalls against the write-back scoreboard, bubbles
// after taken branches, and the interrupt push-slot / vector-load sequence.
module hazard_unit #(
  parameter int unsigned SB_DEPTH    = 2,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_rd_x,
  input  logic [ADDR_W-1:0] dec_rd_y,
  input  logic              dec_uses_x,
  input  logic              dec_uses_y,
  input  logic              dec_rf_wr,
  input  logic [ADDR_W-1:0] dec_wb_addr,
  input  logic              ex_branch_taken,
  input  logic              int_req,
  input  logic              int_en,
  output logic              stall_fd,
  output logic              nop,
  output logic              interupt,
  output logic              pc_vec_ld,
  output logic              int_ack,
  output logic              sb_busy
);

  import cpu_pkg::*;

  localparam int unsigned CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_DEPTH - 1);

  int_state_t       state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             int_armed_q, int_armed_d;
  logic             hit_x, hit_y, raw, flush_active, sb_load;

  assign flush_active = (flush_cnt_q != '0);
  assign raw = dec_valid & ((dec_uses_x & hit_x) | (dec_uses_y & hit_y));
  // The instruction held in decode during INJECT is re-fetched after the ISR,
  // so it must not claim a scoreboard slot.
  assign sb_load = dec_valid & dec_rf_wr & ~nop & ~interupt;

  hazard_scoreboard #(
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (sb_load),
    .load_addr (dec_wb_addr),
    .rd_x      (dec_rd_x),
    .rd_y      (dec_rd_y),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .busy      (sb_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      int_armed_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      int_armed_q <= int_armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (int_req && int_en && int_armed_q && !raw && !flush_active && !ex_branch_taken)
          state_d = INJECT;
      INJECT:  state_d = ex_branch_taken ? IDLE : VECTOR;
      VECTOR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (ex_branch_taken)   flush_cnt_d = FLUSH_RELOAD;
    else if (flush_active) flush_cnt_d = flush_cnt_q - 1'b1;
    else if (pc_vec_ld)    flush_cnt_d = FLUSH_RELOAD;
  end

  // Disarm only when the vector is really taken; re-arm once software drops I.
  always_comb begin
    int_armed_d = int_armed_q;
    if (pc_vec_ld)    int_armed_d = 1'b0;
    else if (!int_en) int_armed_d = 1'b1;
  end

  // Gated by rst_n so every output falls as soon as reset asserts.
  always_comb begin
    stall_fd  = 1'b0;
    nop       = 1'b0;
    interupt  = 1'b0;
    pc_vec_ld = 1'b0;
    int_ack   = 1'b0;
    if (rst_n) begin
      if (ex_branch_taken || flush_active) begin
        nop = 1'b1;
      end else if (state_q == INJECT) begin
        interupt = 1'b1;
        stall_fd = 1'b1;
      end else if (state_q == VECTOR) begin
        pc_vec_ld = 1'b1;
        int_ack   = 1'b1;
        nop       = 1'b1;
      end else if (raw) begin
        nop      = 1'b1;
        stall_fd = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: stimulus queues the expected output
// vector per cycle, an independent monitor pops and compares on the falling edge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid, dec_uses_x, dec_uses_y, dec_rf_wr;
  logic [4:0] dec_rd_x, dec_rd_y, dec_wb_addr;
  logic       ex_branch_taken, int_req, int_en;
  logic       stall_fd, nop, interupt, pc_vec_ld, int_ack, sb_busy;

  // Vector order: {stall_fd, nop, interupt, pc_vec_ld, int_ack, sb_busy}
  localparam logic [5:0] Z     = 6'b000000;
  localparam logic [5:0] BUSY  = 6'b000001;
  localparam logic [5:0] STALL = 6'b110001;
  localparam logic [5:0] BUB   = 6'b010000;
  localparam logic [5:0] BUBB  = 6'b010001;
  localparam logic [5:0] INJ   = 6'b101000;
  localparam logic [5:0] VEC   = 6'b010110;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .SB_DEPTH    (2),
    .FLUSH_DEPTH (2),
    .ADDR_W      (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dec_valid       (dec_valid),
    .dec_rd_x        (dec_rd_x),
    .dec_rd_y        (dec_rd_y),
    .dec_uses_x      (dec_uses_x),
    .dec_uses_y      (dec_uses_y),
    .dec_rf_wr       (dec_rf_wr),
    .dec_wb_addr     (dec_wb_addr),
    .ex_branch_taken (ex_branch_taken),
    .int_req         (int_req),
    .int_en          (int_en),
    .stall_fd        (stall_fd),
    .nop             (nop),
    .interupt        (interupt),
    .pc_vec_ld       (pc_vec_ld),
    .int_ack         (int_ack),
    .sb_busy         (sb_busy)
  );

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {stall_fd, nop, interupt, pc_vec_ld, int_ack, sb_busy};
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic set_dec(input logic v, input logic [4:0] rx, input logic [4:0] ry,
                         input logic ux, input logic uy, input logic wr,
                         input logic [4:0] wa);
    dec_valid   = v;
    dec_rd_x    = rx;
    dec_rd_y    = ry;
    dec_uses_x  = ux;
    dec_uses_y  = uy;
    dec_rf_wr   = wr;
    dec_wb_addr = wa;
  endtask

  task automatic idle_dec();
    set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic expect_now(input string nm, input logic [5:0] e);
    exp_t t;
    t.name = nm;
    t.exp  = e;
    q.push_back(t);
  endtask

  task automatic tick(input string nm, input logic [5:0] e);
    expect_now(nm, e);
    @(posedge clk);
    #1;
  endtask

  // Checks this cycle, then pulses reset entirely between two rising edges.
  task automatic tick_then_reset_pulse(input string nm, input logic [5:0] e);
    expect_now(nm, e);
    @(negedge clk);
    #1 rst_n = 1'b0;
    idle_dec();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_dec();
    ex_branch_taken = 1'b1;
    int_req = 1'b1;
    int_en  = 1'b1;
    @(posedge clk);
    #1;
    tick("rst_hold", Z);
    ex_branch_taken = 1'b0;
    int_req = 1'b0;
    rst_n   = 1'b1;
    tick("rst_release", Z);

    // RAW on X: two stall cycles, then issue
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5); tick("wr_r5", Z);
    set_dec(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick("raw_x_1", STALL);
    tick("raw_x_2", STALL);
    tick("raw_x_issue", Z);
    // independent reader, unused Y match, then Y hit on the WB slot
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5); tick("wr_r5_b", Z);
    set_dec(1'b1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0); tick("indep_r6", BUSY);
    set_dec(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0); tick("raw_y_wb", STALL);
    tick("raw_y_issue", Z);
    // register 0 is ordinary
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0); tick("wr_r0", Z);
    set_dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0); tick("raw_r0", STALL);
    idle_dec();
    tick("r0_draining", BUSY);
    tick("sb_empty", Z);

    // Taken branch: two bubbles, no entries from squashed writers
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    ex_branch_taken = 1'b1; tick("br_hit", BUB);
    ex_branch_taken = 1'b0; tick("br_flush2", BUB);
    tick("br_done", Z);
    idle_dec();
    ex_branch_taken = 1'b1; tick("br_a", BUBB);
    tick("br_reload", BUBB);
    ex_branch_taken = 1'b0; tick("br_reload_tail", BUB);
    tick("br_reload_done", Z);

    // Interrupt from idle, no re-entry on held level until I is cleared
    int_en = 1'b1; int_req = 1'b1; tick("irq_req", Z);
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9); tick("irq_inject", INJ);
    tick("irq_vector", VEC);
    idle_dec();
    tick("irq_tail", BUB);
    tick("irq_no_reentry_1", Z);
    tick("irq_no_reentry_2", Z);
    int_en = 1'b0; tick("irq_i_clear", Z);
    int_en = 1'b1; tick("irq_rearm", Z);
    tick("irq_inject2", INJ);
    tick("irq_vector2", VEC);
    int_req = 1'b0; tick("irq_tail2", BUB);
    tick("irq_quiet", Z);

    // Interrupt raised during a RAW stall is deferred until raw clears
    int_en = 1'b0; tick("raw_irq_arm", Z);
    int_en = 1'b1;
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3); tick("raw_irq_wr", Z);
    set_dec(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0);
    int_req = 1'b1;
    tick("raw_irq_stall1", STALL);
    tick("raw_irq_stall2", STALL);
    tick("raw_irq_clear", Z);
    idle_dec();
    tick("raw_irq_inject", INJ);
    tick("raw_irq_vector", VEC);
    int_req = 1'b0; tick("raw_irq_tail", BUB);
    tick("raw_irq_quiet", Z);

    // Branch coincident with INJECT: vector skipped, retried after flush
    int_en = 1'b0; tick("bri_arm", Z);
    int_en = 1'b1; int_req = 1'b1; tick("bri_req", Z);
    ex_branch_taken = 1'b1; tick("bri_inject_br", BUB);
    ex_branch_taken = 1'b0; tick("bri_flush", BUB);
    tick("bri_retry", Z);
    tick("bri_inject", INJ);

    // Reset pulse inside VECTOR; held request is re-serviced from IDLE
    tick_then_reset_pulse("rst_mid_vec", VEC);
    tick("rst_reinject", INJ);
    tick("rst_revector", VEC);
    int_req = 1'b0; tick("rst_tail", BUB);
    tick("rst_quiet", Z);

    // Reset pulse clears a live scoreboard entry
    set_dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4); tick("sb_wr_r4", Z);
    idle_dec();
    tick_then_reset_pulse("sb_busy_pre", BUSY);
    tick("sb_cleared", Z);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
